// File: rtl/keypad_emulator_if.sv
// ---------------------------------------------------------------------------
// keypad_emulator_if
// Bundles the press-command handshake and the scanner-facing matrix lines of
// the keypad emulator.
//   master : command source / scanner side (drives key_valid, key_hex,
//            hold_cycles, row; observes key_ready, col, contact, busy, done)
//   slave  : the emulator itself
// ---------------------------------------------------------------------------
interface keypad_emulator_if;
    logic        key_valid;
    logic [3:0]  key_hex;
    logic [15:0] hold_cycles;
    logic        key_ready;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        contact;
    logic        busy;
    logic        done;

    modport master (
        output key_valid, key_hex, hold_cycles, row,
        input  key_ready, col, contact, busy, done
    );

    modport slave (
        input  key_valid, key_hex, hold_cycles, row,
        output key_ready, col, contact, busy, done
    );
endinterface

// File: rtl/keypad_emulator.sv
// ---------------------------------------------------------------------------
// keypad_emulator
// Behaves like a 4x4 matrix keypad with one switch pressed on command. The
// scanner drives rows; col returns the pressed key's column whenever that
// key's row is driven and the (registered) switch contact is closed.
//
// Ports
//   clk, reset : clock, synchronous active-high reset
//   kp (slave) : key_valid/key_hex/hold_cycles/key_ready command handshake,
//                row in, col/contact/busy/done out
//
// Build option
//   KEYPAD_BOUNCE_EN : when defined, contact chatters (LFSR driven) for
//                      BOUNCE_CYCLES cycles on press and on release. When
//                      undefined the contact is a clean step.
// ---------------------------------------------------------------------------
module keypad_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 64,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    keypad_emulator_if.slave  kp
);
    typedef enum logic [2:0] {
        S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP
    } state_t;

    // Counters hold "cycles remaining - 1"; a zero length is stretched to 1.
    localparam logic [15:0] GAP_LOAD = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  key_row_q, key_row_d;
    logic [1:0]  key_col_q, key_col_d;
    logic        contact_q, contact_d;
    logic [15:0] hold_eff;
    logic [3:0]  key_pos;

    // Keypad legend -> {row, col}
    function automatic logic [3:0] decode(input logic [3:0] hex);
        case (hex)
            4'h1: decode = {2'd0, 2'd0};
            4'h2: decode = {2'd0, 2'd1};
            4'h3: decode = {2'd0, 2'd2};
            4'hA: decode = {2'd0, 2'd3};
            4'h4: decode = {2'd1, 2'd0};
            4'h5: decode = {2'd1, 2'd1};
            4'h6: decode = {2'd1, 2'd2};
            4'hB: decode = {2'd1, 2'd3};
            4'h7: decode = {2'd2, 2'd0};
            4'h8: decode = {2'd2, 2'd1};
            4'h9: decode = {2'd2, 2'd2};
            4'hC: decode = {2'd2, 2'd3};
            4'hE: decode = {2'd3, 2'd0};
            4'h0: decode = {2'd3, 2'd1};
            4'hF: decode = {2'd3, 2'd2};
            default: decode = {2'd3, 2'd3}; // 4'hD
        endcase
    endfunction

    assign hold_eff = (kp.hold_cycles == 16'd0) ? 16'd1 : kp.hold_cycles;
    assign key_pos  = decode(kp.key_hex);

`ifdef KEYPAD_BOUNCE_EN
    localparam logic [15:0] BOUNCE_LOAD = (BOUNCE_CYCLES == 0) ? 16'd0 : 16'(BOUNCE_CYCLES - 1);

    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] hold_q, hold_d;   // HOLD starts after bounce, so keep the length

    // Fibonacci, taps 16,14,13,11; new bit enters at bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
`else
    logic unused_cfg;
    assign unused_cfg = ^{LFSR_SEED, 32'(BOUNCE_CYCLES)};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_row_d = key_row_q;
        key_col_d = key_col_q;
`ifdef KEYPAD_BOUNCE_EN
        hold_d    = hold_q;
        lfsr_d    = lfsr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (kp.key_valid) begin
                    key_row_d = key_pos[3:2];
                    key_col_d = key_pos[1:0];
`ifdef KEYPAD_BOUNCE_EN
                    hold_d  = hold_eff;
                    state_d = S_BOUNCE_IN;
                    cnt_d   = BOUNCE_LOAD;
`else
                    state_d = S_HOLD;
                    cnt_d   = hold_eff - 16'd1;
`endif
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            S_BOUNCE_IN: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_HOLD;
                    cnt_d   = hold_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_BOUNCE_OUT: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            S_HOLD: begin
                if (cnt_q == 16'd0) begin
`ifdef KEYPAD_BOUNCE_EN
                    state_d = S_BOUNCE_OUT;
                    cnt_d   = BOUNCE_LOAD;
`else
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
`endif
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        // Contact follows the state being entered, so it is registered
        // alongside it and first changes the cycle after accept.
        contact_d = (state_d == S_HOLD);
`ifdef KEYPAD_BOUNCE_EN
        if (state_d == S_BOUNCE_IN || state_d == S_BOUNCE_OUT) begin
            lfsr_d    = lfsr_step(lfsr_q);
            contact_d = lfsr_d[0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            key_row_q <= 2'd3;   // hex 0 position
            key_col_q <= 2'd1;
            contact_q <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
            hold_q    <= 16'd1;
            lfsr_q    <= LFSR_SEED;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_row_q <= key_row_d;
            key_col_q <= key_col_d;
            contact_q <= contact_d;
`ifdef KEYPAD_BOUNCE_EN
            hold_q    <= hold_d;
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign kp.key_ready = (state_q == S_IDLE);
    assign kp.busy      = (state_q != S_IDLE);
    assign kp.done      = (state_q == S_GAP) && (cnt_q == 16'd0);
    assign kp.contact   = contact_q;
    // Switch path: purely combinational from row, like a real closed contact.
    assign kp.col       = (contact_q && kp.row[key_row_q]) ? (4'b0001 << key_col_q) : 4'b0000;

endmodule

// File: tb/tb_keypad_emulator.sv
// ---------------------------------------------------------------------------
// tb_keypad_emulator
// Directed and randomized presses checked against a cycle-indexed model:
// after an accept, cycle k (1-based) of the press is classified by plain
// arithmetic on the bounce/hold/gap lengths, and the expected column comes
// from a legend table lookup.
// ---------------------------------------------------------------------------
module tb_keypad_emulator;
    localparam int GAP = 16;
`ifdef KEYPAD_BOUNCE_EN
    localparam int BNC = 64;
`else
    localparam int BNC = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] ref_lfsr;

    // Legend table, [row][col]
    int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    keypad_emulator_if kif ();

    keypad_emulator dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic find_key(input int hex, output int r, output int c);
        r = 0; c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (keymap[i][j] == hex) begin r = i; c = j; end
    endtask

    // Drive a command; the following posedge is the accept edge.
    task automatic do_accept(input int hex, input int hold);
        kif.key_valid   = 1'b1;
        kif.key_hex     = 4'(hex);
        kif.hold_cycles = 16'(hold);
        chk("ready_before_accept", 16'(kif.key_ready), 16'd1);
        @(posedge clk);
    endtask

    // Walk a whole press after its accept edge. mode: 0 constant row,
    // 1 rotating one-hot row, 2 random row. nv/nh/nhold are what the
    // command port carries meanwhile (ignored by a busy emulator).
    task automatic run_press(input int hex, input int hold, input int mode, input logic [3:0] rowc,
                             input logic nv, input int nh, input int nhold);
        int r, c, heff, len;
        logic ec;
        find_key(hex, r, c);
        heff = (hold == 0) ? 1 : hold;
        len  = 2 * BNC + heff + GAP;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            kif.key_valid   = nv;
            kif.key_hex     = 4'(nh);
            kif.hold_cycles = 16'(nhold);
            case (mode)
                0:       kif.row = rowc;
                1:       kif.row = 4'b0001 << ((k - 1) % 4);
                default: kif.row = 4'($urandom_range(0, 15));
            endcase
            if (k <= BNC || (k > BNC + heff && k <= 2 * BNC + heff)) begin
                ref_lfsr = {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
                ec = ref_lfsr[0];
            end else begin
                ec = (k > BNC && k <= BNC + heff);
            end
            #1;
            chk("contact", 16'(kif.contact), 16'(ec));
            chk("col", 16'(kif.col), (ec && kif.row[r]) ? 16'(1 << c) : 16'd0);
            chk("busy", 16'(kif.busy), 16'(k <= len));
            chk("ready", 16'(kif.key_ready), 16'(k > len));
            chk("done", 16'(kif.done), 16'(k == len));
        end
    endtask

    initial begin
        int hx, hd, md;
        reset           = 1'b1;
        kif.key_valid   = 1'b0;
        kif.key_hex     = 4'h0;
        kif.hold_cycles = 16'd0;
        kif.row         = 4'b1111;
        ref_lfsr        = 16'hACE1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_contact", 16'(kif.contact), 16'd0);
        chk("rst_col", 16'(kif.col), 16'd0);
        chk("rst_busy", 16'(kif.busy), 16'd0);
        chk("rst_done", 16'(kif.done), 16'd0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_ready", 16'(kif.key_ready), 16'd1);

        // Clean press, key 5, row 1 held
        do_accept(5, 10);
        run_press(5, 10, 0, 4'b0010, 1'b0, 0, 0);

        // Row gating, key d, rotating row
        do_accept(13, 12);
        run_press(13, 12, 1, 4'b0000, 1'b0, 0, 0);

        // hold 0 -> one cycle; key 0 sits at (r3,c1)
        do_accept(0, 0);
        run_press(0, 0, 0, 4'b1000, 1'b0, 0, 0);

        // Wrong row only -> col stays 0
        do_accept(2, 6);
        run_press(2, 6, 0, 4'b0100, 1'b0, 0, 0);

        // Busy reject: key 9 requested throughout key 1's press, taken after
        do_accept(1, 8);
        run_press(1, 8, 0, 4'b0001, 1'b1, 9, 5);
        @(posedge clk);
        run_press(9, 5, 0, 4'b0100, 1'b0, 0, 0);

        // Randomized presses
        for (int n = 0; n < 8; n++) begin
            hx = int'($urandom_range(0, 15));
            hd = int'($urandom_range(0, 20));
            md = int'($urandom_range(0, 2));
            @(negedge clk);
            do_accept(hx, hd);
            run_press(hx, hd, md, 4'b1111, 1'b0, 0, 0);
        end

        // Mid-press reset during HOLD
        @(negedge clk);
        do_accept(7, 20);
        repeat (BNC + 4) @(negedge clk);
        kif.key_valid = 1'b0;
        kif.row       = 4'b0100;
        reset         = 1'b1;
        @(negedge clk); #1;
        chk("mrst_contact", 16'(kif.contact), 16'd0);
        chk("mrst_col", 16'(kif.col), 16'd0);
        chk("mrst_busy", 16'(kif.busy), 16'd0);
        chk("mrst_done", 16'(kif.done), 16'd0);
        reset    = 1'b0;
        ref_lfsr = 16'hACE1;
        for (int k = 0; k < GAP + 24; k++) begin
            @(negedge clk); #1;
            chk("mrst_idle_ready", 16'(kif.key_ready), 16'd1);
            chk("mrst_idle_done", 16'(kif.done), 16'd0);
            chk("mrst_idle_col", 16'(kif.col), 16'd0);
        end

        // Recovery press after reset
        do_accept(12, 3);
        run_press(12, 3, 0, 4'b0100, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
